dp_arbiter: RTL

Two-port arbiter and sequencer in front of the `top_main` datapath. Two independent requesters submit datapath operations: opcode, register selects, destination register, memory address and data. The block grants the datapath to one requester at a time in round-robin order and drives the datapath control/operand inputs for exactly one issue cycle. It then waits a fixed pipeline latency, captures the result and zero flag, and returns them to the requester through a valid/ready response channel.

---
 rtl/dp_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/dp_arbiter.sv
// Two-requester round-robin arbiter that issues one datapath operation at a time,
// waits a fixed pipeline latency and returns the captured result over a valid/ready channel.
module dp_arbiter #(
    parameter int DATA_W = 8,
    parameter int OPC_W  = 3,
    parameter int REG_AW = 3,
    parameter int MEM_AW = 4,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OPC_W-1:0]  req0_opcode,
    input  logic [REG_AW-1:0] req0_reg1,
    input  logic [REG_AW-1:0] req0_reg2,
    input  logic [REG_AW-1:0] req0_wreg,
    input  logic [MEM_AW-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OPC_W-1:0]  req1_opcode,
    input  logic [REG_AW-1:0] req1_reg1,
    input  logic [REG_AW-1:0] req1_reg2,
    input  logic [REG_AW-1:0] req1_wreg,
    input  logic [MEM_AW-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic [OPC_W-1:0]  dp_opcode,
    output logic [REG_AW-1:0] dp_reg1,
    output logic [REG_AW-1:0] dp_reg2,
    output logic [REG_AW-1:0] dp_write_address_reg,
    output logic [MEM_AW-1:0] dp_address_mem,
    output logic [DATA_W-1:0] dp_data_in,
    output logic              dp_issue,
    input  logic [DATA_W-1:0] dp_data_out_mem,
    input  logic              dp_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [REG_AW-1:0] reg1;
        logic [REG_AW-1:0] reg2;
        logic [REG_AW-1:0] wreg;
        logic [MEM_AW-1:0] addr;
        logic [DATA_W-1:0] data;
    } op_t;

    localparam logic [2:0] WAIT_LOAD = 3'(LAT - 1);

    state_t            state_q, state_d;
    op_t               op_q, op_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              id_q, id_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_zero_q, rsp_zero_d;

    logic grant0, grant1;
    op_t  req0_op, req1_op;

    assign req0_op = '{req0_opcode, req0_reg1, req0_reg2, req0_wreg, req0_addr, req0_data};
    assign req1_op = '{req1_opcode, req1_reg1, req1_reg2, req1_wreg, req1_addr, req1_data};

    // On a tie the requester not granted last wins.
    assign grant0 = req0_valid && (!req1_valid ||  last_grant_q);
    assign grant1 = req1_valid && (!req0_valid || !last_grant_q);

    assign req0_ready = (state_q == S_IDLE) && grant0;
    assign req1_ready = (state_q == S_IDLE) && grant1;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        rsp_data_d   = rsp_data_q;
        rsp_zero_d   = rsp_zero_q;

        case (state_q)
            S_IDLE: begin
                if (grant0 || grant1) begin
                    op_d         = grant1 ? req1_op : req0_op;
                    id_d         = grant1;
                    last_grant_d = grant1;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (LAT == 1) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d   = WAIT_LOAD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd1) state_d = S_RESP;
                else               cnt_d   = cnt_q - 3'd1;
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Datapath result is sampled only on the edge that enters RESP.
        if (state_d == S_RESP && state_q != S_RESP) begin
            rsp_data_d = dp_data_out_mem;
            rsp_zero_d = dp_zero;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            rsp_data_q   <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

    assign dp_issue             = (state_q == S_ISSUE);
    assign dp_opcode            = dp_issue ? op_q.opcode : '0;
    assign dp_reg1              = op_q.reg1;
    assign dp_reg2              = op_q.reg2;
    assign dp_write_address_reg = op_q.wreg;
    assign dp_address_mem       = op_q.addr;
    assign dp_data_in           = op_q.data;

    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;
    assign busy      = (state_q != S_IDLE);

endmodule
